// File: rtl/wbload_ctrl.sv
// Weight-buffer load controller.
// Takes NORMAL / CONTINUE / RESET / STOP commands. It turns a weight count
// into a count of 64-bit global-buffer words and issues one read request per
// word through a req/gnt handshake. Between commands it keeps a persistent
// read pointer, so a CONTINUE resumes where the previous load stopped.
module wbload_ctrl #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd,
    input  logic [1:0]        cmd_prec,
    input  logic [ADDR_W-1:0] cmd_base_addr,
    input  logic [LEN_W-1:0]  cmd_num_weight,
    output logic              gb_rd_req,
    input  logic              gb_rd_gnt,
    output logic [ADDR_W-1:0] gb_rd_addr,
    output logic              gb_rd_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_ptr
);

    typedef enum logic [1:0] {
        CMD_NORMAL   = 2'd0,
        CMD_CONTINUE = 2'd1,
        CMD_RESET    = 2'd2,
        CMD_STOP     = 2'd3
    } wbload_cmd_e;

    typedef enum logic [1:0] {
        PREC_16B = 2'd0,
        PREC_8B  = 2'd1,
        PREC_4B  = 2'd2,
        PREC_2B  = 2'd3
    } precision_weight_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e            state;
    state_e            next_state;
    precision_weight_e prec_q;
    logic [LEN_W-1:0]  num_q;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  word_count;
    wbload_cmd_e       cmd_in;
    logic              cmd_fire;
    logic              rd_fire;
    logic              stop_fire;
    logic              last_word;

    // Weights per 64-bit word is 4/8/16/32, so the division is a right shift by
    // 2..5. The sum is one bit wider than the count so that rounding up a
    // near-maximum count cannot wrap to a small value.
    function automatic logic [LEN_W-1:0] calc_word_count(
        input precision_weight_e prec,
        input logic [LEN_W-1:0]  num
    );
        logic [LEN_W:0] num_ext;
        logic [LEN_W:0] round_add;
        logic [LEN_W:0] words;
        logic [2:0]     shamt;
        num_ext = {1'b0, num};
        unique case (prec)
            PREC_16B: begin round_add = (LEN_W+1)'(3);  shamt = 3'd2; end
            PREC_8B:  begin round_add = (LEN_W+1)'(7);  shamt = 3'd3; end
            PREC_4B:  begin round_add = (LEN_W+1)'(15); shamt = 3'd4; end
            default:  begin round_add = (LEN_W+1)'(31); shamt = 3'd5; end
        endcase
        words = (num_ext + round_add) >> shamt;
        return LEN_W'(words);
    endfunction

    assign cmd_in     = wbload_cmd_e'(cmd);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign rd_fire    = gb_rd_req && gb_rd_gnt;
    assign stop_fire  = (state == ST_READ) && cmd_fire;
    assign last_word  = (remaining == LEN_W'(1));
    assign word_count = calc_word_count(prec_q, num_q);
    assign gb_rd_addr = rd_ptr;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    // NOTE: next_state is defaulted first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    unique case (cmd_in)
                        CMD_NORMAL,
                        CMD_CONTINUE: next_state = ST_CALC;
                        default:      next_state = ST_DONE;
                    endcase
                end
            end
            ST_CALC: begin
                next_state = (word_count == '0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                // A STOP ends the load, but a grant in the same cycle still counts.
                if (stop_fire || (rd_fire && last_word)) begin
                    next_state = ST_DONE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        cmd_ready  = 1'b0;
        gb_rd_req  = 1'b0;
        gb_rd_last = 1'b0;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_READ: begin
                // During a load only STOP is accepted; other commands wait for IDLE.
                cmd_ready  = cmd_valid && (cmd_in == CMD_STOP);
                gb_rd_req  = 1'b1;
                gb_rd_last = last_word;
            end
            default: begin
            end
        endcase
    end

    // Command latching, read pointer and remaining-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            prec_q    <= PREC_16B;
            num_q     <= '0;
            remaining <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        unique case (cmd_in)
                            CMD_NORMAL: begin
                                rd_ptr <= cmd_base_addr;
                                prec_q <= precision_weight_e'(cmd_prec);
                                num_q  <= cmd_num_weight;
                            end
                            CMD_CONTINUE: begin
                                prec_q <= precision_weight_e'(cmd_prec);
                                num_q  <= cmd_num_weight;
                            end
                            CMD_RESET: begin
                                rd_ptr <= cmd_base_addr;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_CALC: begin
                    remaining <= word_count;
                end
                ST_READ: begin
                    if (rd_fire) begin
                        // The pointer wraps naturally at 2^ADDR_W.
                        rd_ptr    <= rd_ptr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbload_ctrl.sv
// Directed testbench for wbload_ctrl. A negedge monitor records every granted
// read and every done cycle. The directed steps compare those records and the
// DUT outputs against hand-computed values.
module tb_wbload_ctrl;

    localparam logic [1:0] C_NORMAL   = 2'd0;
    localparam logic [1:0] C_CONTINUE = 2'd1;
    localparam logic [1:0] C_RESET    = 2'd2;
    localparam logic [1:0] C_STOP     = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd;
    logic [1:0]  cmd_prec;
    logic [15:0] cmd_base_addr;
    logic [15:0] cmd_num_weight;
    logic        gb_rd_req;
    logic        gb_rd_gnt;
    logic [15:0] gb_rd_addr;
    logic        gb_rd_last;
    logic        busy;
    logic        done;
    logic [15:0] rd_ptr;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int d0;

    logic [15:0] rd_addr_q[$];
    logic        rd_last_q[$];

    wbload_ctrl #(.ADDR_W(16), .LEN_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd           (cmd),
        .cmd_prec      (cmd_prec),
        .cmd_base_addr (cmd_base_addr),
        .cmd_num_weight(cmd_num_weight),
        .gb_rd_req     (gb_rd_req),
        .gb_rd_gnt     (gb_rd_gnt),
        .gb_rd_addr    (gb_rd_addr),
        .gb_rd_last    (gb_rd_last),
        .busy          (busy),
        .done          (done),
        .rd_ptr        (rd_ptr)
    );

    always #5 clk = ~clk;

    // Record granted reads and done cycles mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (gb_rd_req && gb_rd_gnt) begin
            rd_addr_q.push_back(gb_rd_addr);
            rd_last_q.push_back(gb_rd_last);
        end
        if (done) done_cnt++;
    end

    // Hard stop if the bench itself ever stalls.
    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic [1:0] c, input logic [1:0] p,
                            input logic [15:0] base, input logic [15:0] num);
        int n;
        cmd_valid      = 1'b1;
        cmd            = c;
        cmd_prec       = p;
        cmd_base_addr  = base;
        cmd_num_weight = num;
        #1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("cmd_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_reads(input string tag, input int n, input logic [15:0] base,
                               input int last_idx);
        logic [15:0] exp_addr;
        check({tag, "_count"}, rd_addr_q.size(), n);
        for (int i = 0; i < rd_addr_q.size() && i < n; i++) begin
            exp_addr = base + 16'(i);
            check($sformatf("%s_addr%0d", tag, i), rd_addr_q[i], exp_addr);
            check($sformatf("%s_last%0d", tag, i), rd_last_q[i], (i == last_idx) ? 1 : 0);
        end
        rd_addr_q.delete();
        rd_last_q.delete();
    endtask

    initial begin
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd            = 2'd0;
        cmd_prec       = 2'd0;
        cmd_base_addr  = 16'h0;
        cmd_num_weight = 16'h0;
        gb_rd_gnt      = 1'b1;
        #1;
        check("rst_req", gb_rd_req, 0);
        check("rst_last", gb_rd_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ptr", rd_ptr, 16'h0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_ready", cmd_ready, 1);

        // NORMAL 8b, 20 weights -> 3 words from 0x100.
        d0 = done_cnt;
        send_cmd(C_NORMAL, 2'd1, 16'h0100, 16'd20);
        check("n1_calc_busy", busy, 1);
        check("n1_calc_noreq", gb_rd_req, 0);
        check("n1_calc_ready", cmd_ready, 0);
        step();
        check("n1_first_req", gb_rd_req, 1);
        check("n1_first_addr", gb_rd_addr, 16'h0100);
        wait_idle("n1", 50);
        check_reads("n1", 3, 16'h0100, 2);
        check("n1_ptr", rd_ptr, 16'h0103);
        check("n1_done", done_cnt, d0 + 1);

        // CONTINUE 2b, 64 weights -> 2 words from the saved pointer.
        d0 = done_cnt;
        send_cmd(C_CONTINUE, 2'd3, 16'hAAAA, 16'd64);
        wait_idle("c1", 50);
        check_reads("c1", 2, 16'h0103, 1);
        check("c1_ptr", rd_ptr, 16'h0105);
        check("c1_done", done_cnt, d0 + 1);

        // Grant withheld for 3 cycles on the second word.
        send_cmd(C_NORMAL, 2'd0, 16'h0200, 16'd12);
        step();
        check("st_addr0", gb_rd_addr, 16'h0200);
        step();
        gb_rd_gnt = 1'b0;
        #1;
        check("st_hold0", gb_rd_addr, 16'h0201);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("st_hold%0d_req", i), gb_rd_req, 1);
            check($sformatf("st_hold%0d_addr", i), gb_rd_addr, 16'h0201);
        end
        gb_rd_gnt = 1'b1;
        wait_idle("st", 50);
        check_reads("st", 3, 16'h0200, 2);
        check("st_ptr", rd_ptr, 16'h0203);

        // STOP during a 10-word load, after 4 grants, with a grant that same cycle.
        d0 = done_cnt;
        send_cmd(C_NORMAL, 2'd0, 16'h0300, 16'd40);
        step();
        for (int i = 0; i < 4; i++) step();
        check("sp_addr_before", gb_rd_addr, 16'h0304);
        cmd_valid = 1'b1;
        cmd       = C_STOP;
        #1;
        check("sp_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        #1;
        check("sp_req_off", gb_rd_req, 0);
        check("sp_done", done, 1);
        check("sp_ptr", rd_ptr, 16'h0305);
        step();
        check("sp_busy", busy, 0);
        step();
        step();
        check_reads("sp", 5, 16'h0300, -1);
        check("sp_done_cnt", done_cnt, d0 + 1);

        // RESET to 0x0FFF: no reads, done pulse.
        d0 = done_cnt;
        send_cmd(C_RESET, 2'd0, 16'h0FFF, 16'd99);
        check("rs_done", done, 1);
        check("rs_noreq", gb_rd_req, 0);
        check("rs_ptr", rd_ptr, 16'h0FFF);
        wait_idle("rs", 10);
        check("rs_done_cnt", done_cnt, d0 + 1);

        // NORMAL with zero weights: pointer loads, no reads, done pulse.
        d0 = done_cnt;
        send_cmd(C_NORMAL, 2'd2, 16'hFFFF, 16'd0);
        wait_idle("z", 10);
        check_reads("z", 0, 16'h0, -1);
        check("z_ptr", rd_ptr, 16'hFFFF);
        check("z_done_cnt", done_cnt, d0 + 1);

        // CONTINUE 16b, 8 weights -> 2 words, wrapping the pointer.
        send_cmd(C_CONTINUE, 2'd0, 16'h1234, 16'd8);
        wait_idle("w", 20);
        check("w_count", rd_addr_q.size(), 2);
        if (rd_addr_q.size() == 2) begin
            check("w_addr0", rd_addr_q[0], 16'hFFFF);
            check("w_addr1", rd_addr_q[1], 16'h0000);
            check("w_last1", rd_last_q[1], 1);
        end
        rd_addr_q.delete();
        rd_last_q.delete();
        check("w_ptr", rd_ptr, 16'h0001);

        // Maximum weight count at 2b: (65535+31)>>5 = 2048 words, no wrap of the sum.
        send_cmd(C_NORMAL, 2'd3, 16'h1000, 16'hFFFF);
        wait_idle("mx", 3000);
        check_reads("mx", 2048, 16'h1000, 2047);
        check("mx_ptr", rd_ptr, 16'h1800);

        // Reset in the middle of a load.
        send_cmd(C_NORMAL, 2'd0, 16'h0400, 16'd40);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mr_req", gb_rd_req, 0);
        check("mr_last", gb_rd_last, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_ptr", rd_ptr, 16'h0);
        step();
        step();
        check_reads("mr", 2, 16'h0400, -1);
        rst_n = 1'b1;
        #1;
        check("mr_ready", cmd_ready, 1);
        step();
        step();
        check("mr_idle_req", gb_rd_req, 0);
        check("mr_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wbload_ctrl.md
WBLOAD_CTRL -- requirements
Module: wbload_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, weight-buffer word address width.
REQ-002 SHALL have parameter LEN_W, default 16, weight-count width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd  input  2  wbload_cmd_e: NORMAL=0, CONTINUE=1, RESET=2, STOP=3.
REQ-008 SHALL have port cmd_prec  input  2  precision_weight_e: 16b=0, 8b=1, 4b=2, 2b=3.
REQ-009 SHALL have port cmd_base_addr  input  ADDR_W  start word address for NORMAL and RESET.
REQ-010 SHALL have port cmd_num_weight  input  LEN_W  number of weights to load.
REQ-011 SHALL have port gb_rd_req  output  1  read request to the global buffer.
REQ-012 SHALL have port gb_rd_gnt  input  1  grant; a read transfers when gb_rd_req and gb_rd_gnt are both high.
REQ-013 SHALL have port gb_rd_addr  output  ADDR_W  read word address (64-bit words).
REQ-014 SHALL have port gb_rd_last  output  1  high with the final read request of a command.
REQ-015 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port rd_ptr  output  ADDR_W  saved next-read pointer.

Function
REQ-018 SHALL implement states IDLE, CALC, READ, DONE.
REQ-019 SHALL drive cmd_ready high in IDLE; in READ high only when cmd_valid and cmd==STOP; low in CALC and DONE.
REQ-020 SHALL on an accepted NORMAL in IDLE: rd_ptr <= cmd_base_addr, latch cmd_prec and cmd_num_weight, go to CALC.
REQ-021 SHALL on an accepted CONTINUE in IDLE: keep rd_ptr, latch cmd_prec and cmd_num_weight, go to CALC.
REQ-022 SHALL on an accepted RESET in IDLE: rd_ptr <= cmd_base_addr, go to DONE, issue no reads.
REQ-023 SHALL on an accepted STOP in IDLE: go to DONE, no other state change.
REQ-024 SHALL in CALC compute word count = (num_weight + wpw - 1) >> log2(wpw), wpw = 4/8/16/32 for prec 0/1/2/3, using LEN_W+1-bit intermediate so num_weight = 2^LEN_W-1 does not overflow.
REQ-025 SHALL go CALC -> DONE when word count is 0, else CALC -> READ with a remaining counter loaded with the word count.
REQ-026 SHALL in READ hold gb_rd_req high with gb_rd_addr = rd_ptr; address stable while req high and gnt low.
REQ-027 SHALL on each grant increment rd_ptr modulo 2^ADDR_W and decrement the remaining counter.
REQ-028 SHALL drive gb_rd_last high exactly when gb_rd_req is high and remaining == 1.
REQ-029 SHALL go READ -> DONE on the grant of the last word; first request asserts two cycles after command acceptance.
REQ-030 SHALL on STOP accepted in READ: count a same-cycle grant (rd_ptr advances), deassert gb_rd_req next cycle, go to DONE.
REQ-031 SHALL in DONE assert done for one cycle, then go to IDLE.
REQ-032 SHALL keep gb_rd_req, gb_rd_last low outside READ.

Reset
REQ-033 SHALL on rst_n low, immediately and at any state: state IDLE, rd_ptr 0, counters 0, gb_rd_req 0, gb_rd_last 0, done 0, busy 0; cmd_ready 1 after release.
REQ-034 SHALL abandon any in-flight command on reset without further requests.

Verification
REQ-035 SHALL cover NORMAL base=0x100, num=20, prec=1 (8b), gnt always high -> reads 0x100,0x101,0x102, last on 0x102, done pulse, rd_ptr=0x103.
REQ-036 SHALL cover CONTINUE num=64, prec=3 (2b) after REQ-035 -> reads 0x103,0x104, rd_ptr=0x105.
REQ-037 SHALL cover gnt low for 3 cycles on second word -> addr held stable, no duplicate/skipped address.
REQ-038 SHALL cover STOP accepted during READ of 10 words after 4 grants, with grant in same cycle -> 5 reads total, rd_ptr=base+5, done pulse, no further req.
REQ-039 SHALL cover RESET base=0x0FFF then NORMAL num=0 -> no reads, done pulses each; then CONTINUE num=8 prec=0 from rd_ptr=0xFFFF -> reads 0xFFFF,0x0000 (wrap).
REQ-040 SHALL cover rst_n asserted mid-READ -> gb_rd_req low immediately, rd_ptr=0, busy 0.
